// File: rtl/uart_aes_pkg.sv
// -----------------------------------------------------------------------------
// uart_aes_pkg
// Shared constants and types for the UART link that carries 128-bit AES
// blocks between the encryption and decryption nodes. Both the block
// transmitter and the block receiver import this package.
//   BLOCK_BYTES / BLOCK_W     : block size in bytes / bits
//   DEFAULT_CLK_FREQ / _BAUD  : default clock (Hz) and line rate (bit/s)
//   rx_state_e                : byte receiver state encoding
// -----------------------------------------------------------------------------
package uart_aes_pkg;

   localparam int BLOCK_BYTES      = 16;
   localparam int BLOCK_W          = 8 * BLOCK_BYTES;
   localparam int DEFAULT_CLK_FREQ = 100_000_000;
   localparam int DEFAULT_BAUD     = 9600;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_e;

endpackage

// File: rtl/uart_byte_rx.sv
// -----------------------------------------------------------------------------
// uart_byte_rx
// Single-byte 8N1 receiver: 2-flop synchroniser, start/data/stop FSM.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   rxd          : asynchronous serial input (idles high)
//   rx_byte      : last assembled byte (valid while byte_stb is high)
//   byte_stb     : one-cycle pulse, byte received with a good stop bit
//   stop_err     : one-cycle pulse, stop bit sampled low
//   start_det    : combinational, falling edge seen while idle this cycle
//   active       : receiver is not in IDLE
// -----------------------------------------------------------------------------
module uart_byte_rx
   import uart_aes_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic [7:0] rx_byte,
   output logic       byte_stb,
   output logic       stop_err,
   output logic       start_det,
   output logic       active
);

   localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

   logic [1:0]       sync_q, sync_d;
   logic             rxs_prev_q, rxs_prev_d;
   rx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             byte_stb_q, byte_stb_d;
   logic             stop_err_q, stop_err_d;

   logic rxs;
   logic fall;

   assign rxs  = sync_q[1];
   assign fall = rxs_prev_q & ~rxs;

   always_comb begin
      sync_d     = {sync_q[0], rxd};
      rxs_prev_d = rxs;
      state_d    = state_q;
      cnt_d      = cnt_q + 1'b1;
      bit_d      = bit_q;
      shift_d    = shift_q;
      byte_stb_d = 1'b0;
      stop_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (fall) begin
               state_d = START;
            end
         end
         START: begin
            // Mid-start-bit check; a line that is high again was a glitch.
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               bit_d = '0;
               state_d = rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               shift_d = {rxs, shift_q[7:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            // Return to IDLE mid-stop-bit so an immediately following
            // start edge is not missed.
            if (cnt_q == CNT_LAST) begin
               state_d    = IDLE;
               byte_stb_d = rxs;
               stop_err_d = ~rxs;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= 2'b11;
         rxs_prev_q <= 1'b1;
         state_q    <= IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         byte_stb_q <= 1'b0;
         stop_err_q <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         rxs_prev_q <= rxs_prev_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         byte_stb_q <= byte_stb_d;
         stop_err_q <= stop_err_d;
      end
   end

   assign rx_byte   = shift_q;
   assign byte_stb  = byte_stb_q;
   assign stop_err  = stop_err_q;
   assign start_det = (state_q == IDLE) && fall;
   assign active    = (state_q != IDLE);

endmodule

// File: rtl/uart_block_rx.sv
// -----------------------------------------------------------------------------
// uart_block_rx
// Receives 8N1 UART bytes and assembles NUM_BYTES consecutive bytes into one
// block (byte k -> data[8k+7:8k]) for the AES decrypt core.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   rxd        : asynchronous serial input (idles high)
//   data       : last completely received block, held until the next one
//   valid      : one-cycle pulse when data has just been updated
//   frame_err  : one-cycle pulse on a bad stop bit (or inter-byte timeout)
//   busy       : byte in flight or block partially received
// Build option: define RX_TIMEOUT_EN to discard a partial block after an idle
// gap of TIMEOUT_BITS bit periods (reported through frame_err).
// -----------------------------------------------------------------------------
module uart_block_rx
   import uart_aes_pkg::*;
#(
   parameter int CLK_FREQ     = DEFAULT_CLK_FREQ,
   parameter int BAUD         = DEFAULT_BAUD,
   parameter int NUM_BYTES    = BLOCK_BYTES,
   parameter int TIMEOUT_BITS = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rxd,
   output logic [8*NUM_BYTES-1:0] data,
   output logic                   valid,
   output logic                   frame_err,
   output logic                   busy
);

   localparam int               CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int               IDX_W        = $clog2(NUM_BYTES);
   localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_BYTES - 1);

   logic [7:0] rx_byte;
   logic       byte_stb;
   logic       stop_err;
   logic       active;

   logic [IDX_W-1:0]              idx_q, idx_d;
   logic [NUM_BYTES-2:0][7:0]     slot_q, slot_d;
   logic [8*NUM_BYTES-1:0]        data_q, data_d;
   logic                          valid_q, valid_d;
   logic                          ferr_q, ferr_d;

`ifdef RX_TIMEOUT_EN
   localparam int               GAP_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int               GAP_W     = $clog2(GAP_LIMIT);
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_LIMIT - 1);

   logic             start_det;
   logic [GAP_W-1:0] gap_q, gap_d;
`endif

   uart_byte_rx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_byte_rx (
      .clk       (clk),
      .rst_n     (rst_n),
      .rxd       (rxd),
      .rx_byte   (rx_byte),
      .byte_stb  (byte_stb),
      .stop_err  (stop_err),
`ifdef RX_TIMEOUT_EN
      .start_det (start_det),
`else
      .start_det (),
`endif
      .active    (active)
   );

   always_comb begin
      slot_d = slot_q;
      for (int i = 0; i < NUM_BYTES - 1; i++) begin
         if (byte_stb && (idx_q == IDX_W'(i))) begin
            slot_d[i] = rx_byte;
         end
      end
   end

   always_comb begin
      idx_d   = idx_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      if (byte_stb) begin
         if (idx_q == IDX_LAST) begin
            // Final byte goes straight into the top of data, not the buffer.
            data_d  = {rx_byte, slot_q};
            valid_d = 1'b1;
            idx_d   = '0;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end else if (stop_err) begin
         ferr_d = 1'b1;
         idx_d  = '0;
      end
`ifdef RX_TIMEOUT_EN
      // Gap counter only runs while idle inside a partial block; a start edge
      // in the expiry cycle wins over the timeout.
      gap_d = gap_q + 1'b1;
      if (active || byte_stb || start_det || (idx_q == '0)) begin
         gap_d = '0;
      end else if (gap_q == GAP_LAST) begin
         gap_d  = '0;
         idx_d  = '0;
         ferr_d = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q   <= '0;
         slot_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         slot_q  <= slot_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

`ifdef RX_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_q <= '0;
      end else begin
         gap_q <= gap_d;
      end
   end
`endif

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign busy      = active || (idx_q != '0);

endmodule

// File: tb/tb_uart_block_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_block_rx
// Scoreboard bench: each block driven onto rxd is pushed to exp_q and popped
// when the DUT raises valid. CLK_FREQ = 16*BAUD, so 16 clocks per bit.
// -----------------------------------------------------------------------------
module tb_uart_block_rx;

   localparam int BAUD     = 100_000;
   localparam int CLK_FREQ = 16 * BAUD;
   localparam int CPB      = 16;

   localparam logic [127:0] HELLO = 128'h48656c6c6f2044722e20416465656c21;
   localparam logic [127:0] CIPH  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] BLK4  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] BLK5A = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
   localparam logic [127:0] BLK5  = 128'hfedcba98765432100123456789abcdef;
   localparam logic [127:0] BLK6  = 128'h5a5aa5a5c3c33c3c0ff0f00f12345678;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         rxd   = 1'b1;
   logic [127:0] data;
   logic         valid;
   logic         frame_err;
   logic         busy;

   always #5 clk = ~clk;

   uart_block_rx #(
      .CLK_FREQ     (CLK_FREQ),
      .BAUD         (BAUD),
      .NUM_BYTES    (16),
      .TIMEOUT_BITS (32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rxd       (rxd),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   int           n_checks = 0;
   int           n_pass   = 0;
   int           cyc      = 0;
   int           n_valid  = 0;
   int           n_ferr   = 0;
   int           last_start_cyc = 0;
   int           lat_start = 0;
   logic         valid_prev = 1'b0;
   logic [127:0] exp_q[$];
   int           valid_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("check %-20s got %h", tag, got);
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Output monitor: pops the scoreboard on every valid pulse.
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid) begin
            n_valid++;
            valid_cyc.push_back(cyc);
            check_val("block_expected", logic'(exp_q.size() > 0), 1'b1);
            if (exp_q.size() > 0) begin
               check_val("block_data", data, exp_q.pop_front());
            end
            check_val("valid_vs_ferr", frame_err, 1'b0);
            check_val("valid_width", valid_prev, 1'b0);
         end
         if (frame_err) n_ferr++;
      end
      valid_prev = valid;
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      logic [9:0] frame;
      frame = {stop_bit, b, 1'b0};
      last_start_cyc = cyc;
      for (int i = 0; i < 10; i++) begin
         rxd = frame[i];
         repeat (CPB) @(negedge clk);
      end
   endtask

   task automatic send_bytes(input logic [127:0] v, input int first, input int last);
      for (int k = first; k <= last; k++) begin
         send_byte(v[8*k +: 8], 1'b1);
      end
   endtask

   task automatic send_block(input logic [127:0] v);
      exp_q.push_back(v);
      send_bytes(v, 0, 15);
   endtask

   task automatic idle_bits(input int n);
      rxd = 1'b1;
      repeat (n * CPB) @(negedge clk);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      rxd   = 1'b1;
      repeat (4) @(negedge clk);
      check_val("rst_data", data, '0);
      check_val("rst_valid", valid, 1'b0);
      check_val("rst_ferr", frame_err, 1'b0);
      check_val("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      idle_bits(2);

      // Plain block, back-to-back bytes; check latency of the last byte.
      send_block(HELLO);
      lat_start = last_start_cyc;
      idle_bits(2);
      check_val("s1_valid_count", n_valid, 1);
      check_val("s1_latency", valid_cyc[0] - lat_start, 156);
      check_val("s1_busy", busy, 1'b0);
      check_val("s1_data_held", data, HELLO);

      // Two blocks with zero gap.
      send_block(CIPH);
      send_block(CIPH);
      idle_bits(2);
      check_val("s2_valid_count", n_valid, 3);
      check_val("s2_spacing", valid_cyc[2] - valid_cyc[1], 16 * 10 * CPB);
      check_val("s2_busy", busy, 1'b0);

      // Short low glitch: rejected at the mid-start-bit sample.
      rxd = 1'b0;
      repeat (4) @(negedge clk);
      check_val("s3_busy_during", busy, 1'b1);
      rxd = 1'b1;
      idle_bits(3);
      check_val("s3_busy_after", busy, 1'b0);
      check_val("s3_no_ferr", n_ferr, 0);
      check_val("s3_no_valid", n_valid, 3);

      // Bad stop bit, then a clean block.
      send_byte(8'h05, 1'b0);
      idle_bits(2);
      check_val("s4_ferr", n_ferr, 1);
      check_val("s4_busy", busy, 1'b0);
      check_val("s4_data_held", data, CIPH);
      send_block(BLK4);
      idle_bits(2);
      check_val("s4_valid_count", n_valid, 4);

      // Reset during byte 9's data bits.
      send_bytes(BLK5A, 0, 8);
      rxd = 1'b0; repeat (CPB) @(negedge clk);
      rxd = 1'b1; repeat (CPB) @(negedge clk);
      rxd = 1'b0; repeat (CPB / 2) @(negedge clk);
      rst_n = 1'b0;
      rxd   = 1'b1;
      @(negedge clk);
      check_val("s5_rst_data", data, '0);
      check_val("s5_rst_busy", busy, 1'b0);
      check_val("s5_rst_valid", valid, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle_bits(2);
      send_block(BLK5);
      idle_bits(2);
      check_val("s5_valid_count", n_valid, 5);
      check_val("s5_ferr", n_ferr, 1);

      // Idle gap inside a partial block.
      send_bytes(BLK6, 0, 2);
      idle_bits(33);
`ifdef RX_TIMEOUT_EN
      check_val("s6_timeout_ferr", n_ferr, 2);
      check_val("s6_busy", busy, 1'b0);
      send_block(BLK6);
      idle_bits(2);
      check_val("s6_valid_count", n_valid, 6);
`else
      check_val("s6_no_ferr", n_ferr, 1);
      check_val("s6_busy_waiting", busy, 1'b1);
      exp_q.push_back(BLK6);
      send_bytes(BLK6, 3, 15);
      idle_bits(2);
      check_val("s6_valid_count", n_valid, 6);
      check_val("s6_busy", busy, 1'b0);
`endif

      check_val("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
